// File: rtl/rot_pkg.sv
// Shared types and the rotated-address mapping for the frame rotation controller.
package rot_pkg;

  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;
  typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DRAIN} state_e;

  localparam int MAX_LOG2_N = 16;
  typedef logic [MAX_LOG2_N-1:0] coord_t;

  // N is a power of two, so N-1-x is ~x within log2_n bits and row*N+col is {row,col}.
  function automatic logic [2*MAX_LOG2_N-1:0] rot_addr(coord_t r, coord_t c, rot_e rot,
                                                       int log2_n);
    coord_t mask;
    coord_t row;
    coord_t col;
    mask = coord_t'((32'd1 << log2_n) - 32'd1);
    row  = r;
    col  = c;
    case (rot)
      ROT_0:   begin row = r;         col = c;         end
      ROT_90:  begin row = ~c & mask; col = r;         end
      ROT_180: begin row = ~r & mask; col = ~c & mask; end
      ROT_270: begin row = c;         col = ~r & mask; end
      default: begin row = r;         col = c;         end
    endcase
    return ({{MAX_LOG2_N{1'b0}}, row} << log2_n) | {{MAX_LOG2_N{1'b0}}, col};
  endfunction

endpackage

// File: rtl/rot_skid_buf.sv
// Two-entry output buffer for rotated pixels; the producer throttles itself from level.
module rot_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic [1:0]   level,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign out_valid = (level != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; out_data is forced to 0 while empty,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rot_frame_ctrl.sv
// Frame sequencer: loads an NxN frame into SRAM, then streams it out rotated.
// Optional horizontal output flip with input port mirror when ROT_MIRROR_EN is defined.
module rot_frame_ctrl
  import rot_pkg::*;
#(
  parameter  int LOG2_N = 10,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = 2 * LOG2_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        rot_sel,
`ifdef ROT_MIRROR_EN
  input  logic              mirror,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sram_we,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              row_last,
  output logic              frame_last,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [LOG2_N-1:0] LAST_COORD = '1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_e              state;
  rot_e                rot_q;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [LOG2_N-1:0]   r_cnt;
  logic [LOG2_N-1:0]   c_cnt;
  logic [LOG2_N-1:0]   c_map;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_pend;
  logic                rd_row_last;
  logic                rd_frame_last;
  logic [1:0]          level;
  logic                pop;
  logic [DATA_W+1:0]   buf_data;

`ifdef ROT_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        mirror_q <= 1'b0;
    else if (state == IDLE && start) mirror_q <= mirror;
  end

  assign c_map = mirror_q ? ~c_cnt : c_cnt;
`else
  assign c_map = c_cnt;
`endif

  assign rd_addr    = ADDR_W'(rot_addr(coord_t'(r_cnt), coord_t'(c_map), rot_q, LOG2_N));
  assign in_ready   = (state == LOAD);
  assign sram_we    = in_ready & in_valid;
  assign pop        = out_valid & out_ready;
  // A read is issued only if its pixel will find room, counting the one in flight
  // and any slot freed by this cycle's pop.
  assign sram_re    = (state == ROTATE) &&
                      ((3'(level) + 3'(rd_pend)) < (3'd2 + 3'(pop)));
  assign sram_addr  = sram_we ? wr_cnt : (sram_re ? rd_addr : '0);
  assign sram_wdata = sram_we ? in_data : '0;
  assign busy       = (state != IDLE);
  assign {row_last, frame_last, out_data} = buf_data;
  assign frame_done = pop & frame_last;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rot_q         <= ROT_0;
      wr_cnt        <= '0;
      r_cnt         <= '0;
      c_cnt         <= '0;
      rd_pend       <= 1'b0;
      rd_row_last   <= 1'b0;
      rd_frame_last <= 1'b0;
    end else begin
      rd_pend       <= sram_re;
      rd_row_last   <= (c_cnt == LAST_COORD);
      rd_frame_last <= (c_cnt == LAST_COORD) && (r_cnt == LAST_COORD);
      case (state)
        IDLE: if (start) begin
          state  <= LOAD;
          rot_q  <= rot_e'(rot_sel);
          wr_cnt <= '0;
          r_cnt  <= '0;
          c_cnt  <= '0;
        end
        LOAD: if (sram_we) begin
          wr_cnt <= wr_cnt + ADDR_W'(1);
          if (wr_cnt == LAST_ADDR) state <= ROTATE;
        end
        ROTATE: if (sram_re) begin
          c_cnt <= c_cnt + LOG2_N'(1);
          if (c_cnt == LAST_COORD) begin
            r_cnt <= r_cnt + LOG2_N'(1);
            if (r_cnt == LAST_COORD) state <= DRAIN;
          end
        end
        DRAIN: if (frame_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  rot_skid_buf #(.W(DATA_W + 2)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data ({rd_row_last, rd_frame_last, sram_rdata}),
    .level     (level),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_data)
  );

endmodule

// File: tb/tb_rot_frame_ctrl.sv
// Self-checking bench for rot_frame_ctrl at LOG2_N=2 (4x4 frames), with a behavioural SRAM.
module tb_rot_frame_ctrl;

  localparam int LOG2_N = 2;
  localparam int N      = 4;
  localparam int NN     = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef logic [N-1:0][N-1:0][7:0] img_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        rot_sel = 2'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              sram_we;
  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              row_last;
  logic              frame_last;
  logic              busy;
  logic              frame_done;
`ifdef ROT_MIRROR_EN
  logic              mirror = 1'b0;
`endif

  logic [7:0] sram_mem [NN];
  logic [7:0] pix [NN];
  logic [9:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= sram_mem[sram_addr];
  end

  rot_frame_ctrl #(.LOG2_N(LOG2_N), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rot_sel    (rot_sel),
`ifdef ROT_MIRROR_EN
    .mirror     (mirror),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sram_we    (sram_we),
    .sram_re    (sram_re),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .row_last   (row_last),
    .frame_last (frame_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic img_t rot_cw(input img_t a);
    img_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = a[N-1-j][i];
    return b;
  endfunction

  // Expected stream: rotate the loaded image clockwise rot times, optionally flip each row.
  task automatic build_expect(input logic [1:0] rot, input bit mir);
    img_t img;
    int   cc;
    for (int i = 0; i < NN; i++) img[i / N][i % N] = pix[i];
    for (int k = 0; k < int'(rot); k++) img = rot_cw(img);
    exp_q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        cc = mir ? N - 1 - c : c;
        exp_q.push_back({(c == N - 1), (r == N - 1 && c == N - 1), img[r][cc]});
      end
  endtask

  function automatic logic [27:0] all_outs();
    return {in_ready, sram_we, sram_re, sram_addr, sram_wdata, out_valid, out_data,
            row_last, frame_last, busy, frame_done};
  endfunction

  task automatic run_frame(input logic [1:0] rot, input bit mir, input bit gaps,
                           input bit stalls, input bit disturb, input int abort_at,
                           input bit timing);
    int         idx = 0;
    int         oidx = 0;
    int         cyc = 0;
    int         last_wr_cyc = -1;
    int         first_ov_cyc = -1;
    bit         stalled = 1'b0;
    bit         done = 1'b0;
    logic [9:0] held = '0;
    build_expect(rot, mir);
    @(negedge clk);
    start   = 1'b1;
    rot_sel = rot;
`ifdef ROT_MIRROR_EN
    mirror  = mir;
`endif
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 2000) begin
      if (abort_at >= 0 && oidx == abort_at) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check("abort_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      in_valid  = (idx < NN) && (!gaps || $urandom_range(0, 1) == 1);
      in_data   = (idx < NN) ? pix[idx] : 8'($urandom);
      out_ready = !stalls || $urandom_range(0, 1) == 1;
      start     = disturb && (oidx == 3 || idx == 8);
      if (disturb && oidx == 3) rot_sel = ~rot;
      #1;
      check("we_re_excl", sram_we & sram_re, 0);
      if (last_wr_cyc >= 0 && cyc == last_wr_cyc + 1) check("in_ready_drop", in_ready, 0);
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (stalled) check("stall_hold", {row_last, frame_last, out_data}, held);
      if (out_valid && out_ready) begin
        if (oidx < NN) begin
          check("out_pix", {row_last, frame_last, out_data}, exp_q[oidx]);
          check("frame_done", frame_done, exp_q[oidx][8]);
        end else begin
          check("extra_out", oidx, NN - 1);
        end
        if (oidx == NN - 1) begin
          done = 1'b1;
          check("busy_at_done", busy, 1);
          if (timing) begin
            check("first_valid_lat", first_ov_cyc, last_wr_cyc + 3);
            check("frame_cycles", cyc, last_wr_cyc + NN + 2);
          end
        end
        oidx++;
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
      stalled = out_valid && !out_ready;
      held    = {row_last, frame_last, out_data};
      if (in_valid && in_ready) begin
        check("sram_wr", {sram_we, sram_addr, sram_wdata}, {1'b1, 4'(idx), pix[idx]});
        if (idx == NN - 1) last_wr_cyc = cyc;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) check("frame_timeout", oidx, NN);
    #1;
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 check("reset_outs", all_outs(), 0);
    #20;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NN; i++) pix[i] = 8'(i);
    run_frame(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    for (int i = 0; i < NN; i++) pix[i] = 8'($urandom);
    run_frame(2'd1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_frame(2'd1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);

    run_frame(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    run_frame(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0);

    for (int i = 0; i < NN; i++) pix[i] = 8'($urandom);
    run_frame(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0);
    run_frame(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);

`ifdef ROT_MIRROR_EN
    for (int i = 0; i < NN; i++) pix[i] = 8'(i);
    run_frame(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rot_frame_ctrl.md
Name: rot_frame_ctrl

Overview:
Frame-level sequencer for the image rotation datapath. It accepts a square 8-bit pixel stream, writes it raster-order into a single-port frame SRAM (LOAD), then generates rotated read addresses and streams the rotated frame out (ROTATE). It sits between the pixel source/sink and the frame SRAM, and replaces the free-running mode-pin control with start/busy/done sequencing and valid/ready handshakes on both streams.

Parameters:
LOG2_N, 10, log2 of frame side; frame is N×N with N = 2**LOG2_N (default 1024×1024)
DATA_W, 8, pixel width
ADDR_W, 2*LOG2_N, SRAM address width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
rot_sel  in  2  0=0°, 1=90° CW, 2=180°, 3=270° CW; sampled on accepted start
in_valid  in  1  input pixel valid
in_ready  out  1  controller can accept an input pixel
in_data  in  DATA_W  input pixel, raster order
sram_we  out  1  SRAM write strobe
sram_re  out  1  SRAM read strobe
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid exactly 1 cycle after sram_re
out_valid  out  1  rotated pixel valid
out_ready  in  1  sink accepts pixel
out_data  out  DATA_W  rotated pixel
row_last  out  1  with out_valid: last pixel of an output row
frame_last  out  1  with out_valid: final pixel of the frame
busy  out  1  high in LOAD/ROTATE/DRAIN
frame_done  out  1  one-cycle pulse when the final pixel is accepted

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; skid buffer empty. Reset mid-frame aborts immediately. SRAM contents are not guaranteed afterwards.
- States: IDLE -> LOAD on start (latch rot_sel) -> ROTATE after the N*N-th write -> DRAIN after the last read is issued -> IDLE when the last pixel is accepted (frame_done pulses that cycle). start while busy is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: sram_we=1, sram_addr=wr_cnt, sram_wdata=in_data, wr_cnt++ in the same cycle (combinational pass-through).
  - Gaps in in_valid stall wr_cnt.
  - Leaving LOAD: in_ready=0 from the cycle after the last write.
- ROTATE:
  - Output coordinates (r,c) are raster-ordered counters.
  - Read address per rot_sel:
    - 0: r*N+c
    - 1: (N-1-c)*N+r
    - 2: (N-1-r)*N+(N-1-c)
    - 3: c*N+(N-1-r)
  - Because N is a power of two, addresses are {row,col} concatenations and N-1-x is bitwise ~x.
  - Issue a read (sram_re=1) only when the skid buffer has room counting the read in flight. No read and no write ever occur in the same cycle.
- Output path:
  - 2-entry skid buffer; out_valid = buffer non-empty.
  - First out_valid occurs 2 cycles after ROTATE entry.
  - With out_ready held high: one pixel/cycle, full frame in N*N+2 cycles from ROTATE entry.
  - While out_valid=1 and out_ready=0, out_data, row_last and frame_last hold stable.
  - row_last/frame_last travel through the buffer alongside their pixel.
- Counter wrap: c wraps at N-1 (r++); the read that wraps r at N-1 moves the state to DRAIN.
- Simultaneous buffer push and pop: occupancy unchanged.

Optional Feature:
ROT_MIRROR_EN:
- Defined: adds input port mirror (1 bit), sampled with rot_sel on start. When set, the output column index c is replaced by N-1-c before the rotation mapping (horizontal flip of the output). Adds no latency.
- Undefined: no port; behaviour exactly as above.

Decomposition:
- Package rot_pkg: rot_e enum (ROT_0, ROT_90, ROT_180, ROT_270), state enum (IDLE, LOAD, ROTATE, DRAIN), and the address-mapping function rot_addr(r, c, rot, LOG2_N).
- Sub-module rot_skid_buf: 2-entry valid/ready buffer, width DATA_W+2.

Test Plan:
- LOG2_N=2, pixels 0..15, rot_sel=0, out_ready=1 -> output 0..15; row_last on 3,7,11,15; frame_last and frame_done on 15; busy falls the next cycle.
- rot_sel=1 -> first row 12,8,4,0; full frame 12,8,4,0,13,9,5,1,14,10,6,2,15,11,7,3.
- rot_sel=2 -> 15,14,...,0; rot_sel=3 -> first row 3,7,11,15.
- rot_sel=1 with random in_valid gaps and out_ready toggled ~50% -> same sequence, no drop or duplicate, out_data stable while stalled, sram_we and sram_re never high together.
- start pulsed during ROTATE, and rot_sel changed mid-frame -> ignored; second start after frame_done runs a new frame with the newly sampled rot_sel.
- rst asserted at pixel 7 of ROTATE -> all outputs 0 asynchronously; after release, a new start completes a correct frame.
- ROT_MIRROR_EN defined, rot_sel=0, mirror=1 -> first row 3,2,1,0.
